// File: rtl/dmem_pkg.sv
// Shared types, constants and the byte-lane decoder for the data-memory responder.
package dmem_pkg;

    localparam int unsigned BYTE_LANES       = 4;
    localparam int unsigned WORD_OFFSET_BITS = 2;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned CNT_W            = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic              byte_acc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

    // One-hot write enable for the byte lane selected by addr[1:0].
    function automatic logic [BYTE_LANES-1:0] lane_we(input logic [WORD_OFFSET_BITS-1:0] lane);
        return BYTE_LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous per-lane write, asynchronous read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic [BYTE_LANES-1:0]          we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] index,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int l = 0; l < BYTE_LANES; l++) begin
            if (we[l]) mem[index][8*l +: 8] <= wdata[8*l +: 8];
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states, held response.
// Optional DMEM_PERF_CNT_EN adds saturating rd_count/wr_count completion counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef DMEM_PERF_CNT_EN
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
`endif
    output logic              rsp_error
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    dmem_req_t         req_q, req_n, acc;
    logic              req_ready_n, rsp_valid_n, rsp_error_n;
    logic [DATA_W-1:0] rsp_rdata_n;

    logic                           accept, access, misaligned;
    logic [WORD_OFFSET_BITS-1:0]    lane;
    logic [BYTE_LANES-1:0]          mem_we;
    logic [IDX_W-1:0]               mem_index;
    logic [DATA_W-1:0]              mem_wdata, mem_rdata, load_data;
    logic                           unused_addr_bits;

    assign accept = (state == IDLE) && req_ready && req_valid;

    // With zero wait states the access happens on the acceptance edge, straight from the inputs.
    always_comb begin
        if (state == IDLE) begin
            acc.write    = req_write;
            acc.byte_acc = req_byte;
            acc.addr     = req_addr;
            acc.wdata    = req_wdata;
        end else begin
            acc = req_q;
        end
    end

    assign access     = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == CNT_W'(1)));
    assign lane       = acc.addr[WORD_OFFSET_BITS-1:0];
    assign misaligned = !acc.byte_acc && (lane != '0);
    assign mem_index  = acc.addr[IDX_W+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
    assign mem_wdata  = acc.byte_acc ? {BYTE_LANES{acc.wdata[7:0]}} : acc.wdata;
    assign mem_we     = (access && acc.write && !misaligned)
                      ? (acc.byte_acc ? lane_we(lane) : '1) : '0;
    assign load_data  = acc.byte_acc ? {24'h0, 8'(mem_rdata >> {lane, 3'b000})} : mem_rdata;

    // Address bits above the array index wrap and are deliberately dropped.
    assign unused_addr_bits = ^acc.addr[ADDR_W-1:IDX_W+WORD_OFFSET_BITS];

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .index (mem_index),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            req_q     <= req_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_error <= rsp_error_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        req_n       = req_q;
        rsp_valid_n = rsp_valid;
        rsp_rdata_n = rsp_rdata;
        rsp_error_n = rsp_error;

        case (state)
            IDLE: begin
                if (accept) begin
                    req_n   = acc;
                    cnt_n   = CNT_W'(WAIT_CYCLES);
                    state_n = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_n = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                    rsp_rdata_n = '0;
                    rsp_error_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (access) begin
            rsp_valid_n = 1'b1;
            rsp_error_n = misaligned;
            rsp_rdata_n = (acc.write || misaligned) ? '0 : load_data;
        end

        req_ready_n = (state_n == IDLE);
    end

`ifdef DMEM_PERF_CNT_EN
    logic done_ok;
    assign done_ok = (state == RESP) && rsp_ready && !rsp_error;

    // Count successful completions at the response handshake, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (done_ok) begin
            if (req_q.write) wr_count <= (wr_count == '1) ? wr_count : wr_count + 32'd1;
            else             rd_count <= (rd_count == '1) ? rd_count : rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a word-array model queues expected responses per request.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WAITS = 2;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_write, req_byte, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_count, wr_count;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;
    exp_t        sb[$];
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
`ifdef DMEM_PERF_CNT_EN
        .rd_count  (rd_count),
        .wr_count  (wr_count),
`endif
        .rsp_error (rsp_error)
    );

    // Reference behaviour: update the model and queue the response the request must produce.
    function automatic void model_push(input logic wr, input logic byt,
                                       input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0] idx;
        logic [1:0] ln;
        exp_t       e;
        idx = addr[9:2];
        ln  = addr[1:0];
        e   = '0;
        if (!byt && ln != 2'd0) begin
            e.err = 1'b1;
        end else if (wr) begin
            if (byt) model[idx][8*ln +: 8] = wdata[7:0];
            else     model[idx] = wdata;
            exp_wr++;
        end else begin
            e.rdata = byt ? {24'h0, model[idx][8*ln +: 8]} : model[idx];
            exp_rd++;
        end
        sb.push_back(e);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where rsp_valid is first seen.
    task automatic xact(input logic wr, input logic byt, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
        model_push(wr, byt, addr, wdata);
        req_valid = 1'b1; req_write = wr; req_byte = byt; req_addr = addr; req_wdata = wdata;
        for (int g = 0; g < 20 && !req_ready; g++) @(negedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            // Scramble the request bus after acceptance; it must be ignored.
            req_write = ~wr; req_byte = ~byt; req_addr = $urandom; req_wdata = $urandom;
            if (rsp_valid) req_valid = 1'b0;
        end while (!rsp_valid && lat < 40);
        req_valid = 1'b0;
        rdata     = rsp_rdata;
        err       = rsp_error;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b want 0/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_error);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
`ifdef DMEM_PERF_CNT_EN
        checks++;
        if (rd_count !== 32'h0 || wr_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters: got rd=%0d wr=%0d want 0/0", rd_count, wr_count);
        end
`endif
    endtask

    task automatic test_word_rw();
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        logic        wr_tab [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            xact(wr_tab[i], 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
            consume();
            e = sb.pop_front();
            checks++;
            if (lat != WAITS + 1) begin
                errors++;
                $display("FAIL word_rw_latency[%0d]: got %0d want %0d", i, lat, WAITS + 1);
            end
            checks++;
            if ({rd, er} !== {e.rdata, e.err}) begin
                errors++;
                $display("FAIL word_rw_data[%0d]: got %h/%b want %h/%b", i, rd, er, e.rdata, e.err);
            end
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_rw_const: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        logic        wr_tab [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        by_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ad_tab [6] = '{32'h10, 32'h13, 32'h10, 32'h13, 32'h11, 32'h10};
        logic [31:0] wd_tab [6] = '{32'h0, 32'h777777A5, 32'h0, 32'h0, 32'hFFFFFF3C, 32'h0};
        logic [31:0] k_tab  [6] = '{32'h0, 32'h0, 32'hA5000000, 32'h000000A5, 32'h0, 32'hA5003C00};
        for (int i = 0; i < 6; i++) begin
            xact(wr_tab[i], by_tab[i], ad_tab[i], wd_tab[i], rd, er, lat);
            consume();
            e = sb.pop_front();
            checks++;
            if ({rd, er} !== {e.rdata, e.err} || rd !== k_tab[i]) begin
                errors++;
                $display("FAIL byte_lane[%0d]: got %h/%b want %h/%b (const %h)",
                         i, rd, er, e.rdata, e.err, k_tab[i]);
            end
        end
    endtask

    task automatic test_error();
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        logic        wr_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad_tab [4] = '{32'h20, 32'h22, 32'h22, 32'h20};
        logic [31:0] wd_tab [4] = '{32'h11111111, 32'h0, 32'hFFFFFFFF, 32'h0};
        logic        ke_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            xact(wr_tab[i], 1'b0, ad_tab[i], wd_tab[i], rd, er, lat);
            consume();
            e = sb.pop_front();
            checks++;
            if ({rd, er} !== {e.rdata, e.err} || er !== ke_tab[i]) begin
                errors++;
                $display("FAIL misaligned[%0d]: got %h/%b want %h/%b", i, rd, er, e.rdata, e.err);
            end
        end
        checks++;
        if (rd !== 32'h11111111) begin
            errors++;
            $display("FAIL misaligned_store_suppressed: got %h want 11111111", rd);
        end
    endtask

    task automatic test_stall();
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        xact(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        e = sb.pop_front();
        checks++;
        if ({rd, er} !== {e.rdata, e.err}) begin
            errors++;
            $display("FAIL stall_data: got %h/%b want %h/%b", rd, er, e.rdata, e.err);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b rdata=%h ready=%b want 1/%h/0",
                         c, rsp_valid, rsp_rdata, req_ready, e.rdata);
            end
        end
        consume();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got valid=%b ready=%b rdata=%h err=%b want 0/1/0/0",
                     rsp_valid, req_ready, rsp_rdata, rsp_error);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        xact(1'b1, 1'b0, 32'h400, 32'h12345678, rd, er, lat);
        consume();
        e = sb.pop_front();
        checks++;
        if ({rd, er} !== {e.rdata, e.err}) begin
            errors++;
            $display("FAIL wrap_store: got %h/%b want %h/%b", rd, er, e.rdata, e.err);
        end
        xact(1'b0, 1'b0, 32'h000, 32'h0, rd, er, lat);
        consume();
        e = sb.pop_front();
        checks++;
        if ({rd, er} !== {e.rdata, e.err} || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL wrap_load: got %h/%b want %h/%b", rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        xact(1'b1, 1'b0, 32'h40, 32'h0, rd, er, lat);
        consume();
        e = sb.pop_front();
        // Start a store that reset abandons; the model is deliberately not updated.
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got valid=%b ready=%b want 0/0", rsp_valid, req_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_held: got valid=%b ready=%b want 0/0", rsp_valid, req_ready);
        end
        reset = 1'b1;
        exp_rd = 0;
        exp_wr = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: got %b want 1", req_ready);
        end
`ifdef DMEM_PERF_CNT_EN
        checks++;
        if (wr_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_wr_count: got %0d want 0", wr_count);
        end
`endif
        xact(1'b0, 1'b0, 32'h40, 32'h0, rd, er, lat);
        consume();
        e = sb.pop_front();
        checks++;
        if ({rd, er} !== {e.rdata, e.err} || rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_abandoned: got %h/%b want %h/%b", rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 32; i++) begin
            if (i < 8) xact(1'b1, 1'b0, 32'h100 + 32'(4*i), $urandom, rd, er, lat);
            else       xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            32'h100 + 32'($urandom_range(0, 31)), $urandom, rd, er, lat);
            consume();
            e = sb.pop_front();
            checks++;
            if ({rd, er} !== {e.rdata, e.err} || lat != WAITS + 1) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h/%b lat=%0d want %h/%b lat=%0d",
                         i, rd, er, lat, e.rdata, e.err, WAITS + 1);
            end
        end
`ifdef DMEM_PERF_CNT_EN
        checks++;
        if (rd_count !== 32'(exp_rd) || wr_count !== 32'(exp_wr)) begin
            errors++;
            $display("FAIL perf_counts: got rd=%0d wr=%0d want rd=%0d wr=%0d",
                     rd_count, wr_count, exp_rd, exp_wr);
        end
`endif
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        test_reset();
        test_word_rw();
        test_byte();
        test_error();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
